// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, NOP encoding,
// and register-file geometry.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          PKG_NREG = 32;
  localparam int          REG_AW   = 5;

endpackage

// File: rtl/pipe_scoreboard.sv
// Pending-write scoreboard for long-latency results plus the ld-stage slot that
// lets a flush undo the scoreboard entry of the instruction it squashes.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG = PKG_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic              i_rd_wr,
  input  logic              i_long,
  input  logic              i_wb_valid,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  output logic              o_hazard,
  output logic [NREG-1:0]   o_sb
);

  logic [NREG-1:0]   r_sb;
  logic              r_slot_vld;
  logic [REG_AW-1:0] r_slot_rd;
  logic [NREG-1:0]   w_sb_nxt;
  logic              w_set;

  assign w_set = i_issue & i_rd_wr & i_long & (i_rd_addr != '0);

  // Hazard is looked up against the registered state, so a write-back only
  // releases a dependent instruction on the following cycle.
  assign o_hazard = i_id_valid & ((i_rs1_used & r_sb[i_rs1_addr]) |
                                  (i_rs2_used & r_sb[i_rs2_addr]));
  assign o_sb = r_sb;

  // Ordering: clears first, set last so a same-cycle set on the same index wins.
  always_comb begin
    w_sb_nxt = r_sb;
    if (i_wb_valid) w_sb_nxt[i_wb_rd_addr] = 1'b0;
    if (i_flush && r_slot_vld) w_sb_nxt[r_slot_rd] = 1'b0;
    if (w_set) w_sb_nxt[i_rd_addr] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sb       <= '0;
      r_slot_vld <= 1'b0;
      r_slot_rd  <= '0;
    end else begin
      r_sb <= w_sb_nxt;
      if (i_issue) begin
        r_slot_vld <= w_set;
        r_slot_rd  <= i_rd_addr;
      end else if (!i_hold || i_flush) begin
        r_slot_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, ex-busy holds, and jump
// redirect with a timed flush of the if/id and ld registers.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32,
  parameter int NREG         = PKG_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_wr_i,
  input  logic            id_long_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            ex_busy_i,
  input  logic            ex_jump_i,
  input  logic [XLEN-1:0] ex_jump_addr_i,
  output logic            pc_hold_o,
  output logic            if_id_hold_o,
  output logic            ld_bubble_o,
  output logic            ld_hold_o,
  output logic            if_id_flush_o,
  output logic            ld_flush_o,
  output logic            pc_load_o,
  output logic [XLEN-1:0] pc_load_addr_o,
  output logic            issue_o,
  output logic [1:0]      state_o,
  output logic [NREG-1:0] sb_o
);

  logic [2:0]      r_flush_cnt;
  state_e          w_state;
  logic            w_flush;
  logic            w_hazard;
  logic [NREG-1:0] w_sb;

  // A fresh jump flushes immediately; the counter only covers the tail cycles.
  assign w_flush = ex_jump_i | (r_flush_cnt != 3'd0);

  always_comb begin
    w_state = ST_RUN;
    if (w_flush)        w_state = ST_FLUSH;
    else if (ex_busy_i) w_state = ST_HOLD;
    else if (w_hazard)  w_state = ST_STALL;
  end

  always_ff @(posedge clk) begin
    if (!rst)                  r_flush_cnt <= 3'd0;
    else if (ex_jump_i)        r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
    else if (r_flush_cnt != 0) r_flush_cnt <= r_flush_cnt - 3'd1;
  end

  assign issue_o        = rst & (w_state == ST_RUN) & id_valid_i;
  assign pc_hold_o      = rst & ((w_state == ST_STALL) | (w_state == ST_HOLD));
  assign if_id_hold_o   = pc_hold_o;
  assign ld_bubble_o    = rst & (w_state == ST_STALL);
  assign ld_hold_o      = rst & (w_state == ST_HOLD);
  assign if_id_flush_o  = rst & (w_state == ST_FLUSH);
  assign ld_flush_o     = if_id_flush_o;
  assign pc_load_o      = rst & ex_jump_i;
  assign pc_load_addr_o = pc_load_o ? ex_jump_addr_i : '0;
  assign state_o        = rst ? w_state : ST_RUN;
  assign sb_o           = rst ? w_sb : '0;

  pipe_scoreboard #(.NREG(NREG)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (issue_o),
    .i_hold       (ld_hold_o),
    .i_flush      (ld_flush_o),
    .i_id_valid   (id_valid_i),
    .i_rs1_addr   (id_rs1_addr_i),
    .i_rs2_addr   (id_rs2_addr_i),
    .i_rs1_used   (id_rs1_used_i),
    .i_rs2_used   (id_rs2_used_i),
    .i_rd_addr    (id_rd_addr_i),
    .i_rd_wr      (id_rd_wr_i),
    .i_long       (id_long_i),
    .i_wb_valid   (wb_valid_i),
    .i_wb_rd_addr (wb_rd_addr_i),
    .o_hazard     (w_hazard),
    .o_sb         (w_sb)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core (pc_reg -> ins_fetch -> decode -> ld -> ex -> regs write-back). Detects read-after-write hazards against long-latency results (loads) using a 32-entry scoreboard. Holds the pipeline while ex is busy with a multi-cycle operation. Redirects the PC and flushes the younger stages on a taken jump or branch from ex.

Parameters:
FLUSH_CYCLES, 2, cycles the if/id and ld flush outputs stay asserted per redirect (range 1..7)
XLEN, 32, address/data width
NREG, 32, architectural register count; x0 is never tracked

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
id_valid_i  in  1  decode holds a valid instruction
id_rs1_addr_i  in  5  source 1 index
id_rs2_addr_i  in  5  source 2 index
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_addr_i  in  5  destination index
id_rd_wr_i  in  1  instruction writes rd
id_long_i  in  1  result arrives late (load); must be scoreboarded
wb_valid_i  in  1  late result written to regs this cycle
wb_rd_addr_i  in  5  index of that write
ex_busy_i  in  1  ex multi-cycle op in progress
ex_jump_i  in  1  taken jump/branch resolved in ex
ex_jump_addr_i  in  XLEN  redirect target
pc_hold_o  out  1  pc_reg keeps current value
if_id_hold_o  out  1  if->id register keeps contents
ld_bubble_o  out  1  ld inserts NOP (32'h00000013) instead of the decode output
ld_hold_o  out  1  ld register keeps contents
if_id_flush_o  out  1  if->id register loads NOP
ld_flush_o  out  1  ld register loads NOP
pc_load_o  out  1  pc_reg loads pc_load_addr_o
pc_load_addr_o  out  XLEN  redirect target
issue_o  out  1  decode instruction advances into ld this cycle
state_o  out  2  FSM state, debug
sb_o  out  NREG  scoreboard, debug

Behaviour:
- Reset (rst==0 at a clk edge): FSM=RUN, flush counter=0, scoreboard=0, ld slot invalid. While rst==0, all outputs are forced to 0; pc_load_addr_o reads 0. A reset during FLUSH or HOLD aborts that state immediately.
- hazard = id_valid_i & ((rs1_used & sb[rs1]) | (rs2_used & sb[rs2])). It is evaluated against the registered scoreboard. A write-back clears its bit at the edge, so a dependent instruction issues one cycle after wb_valid_i.
- Priority each cycle: ex_jump_i > ex_busy_i > hazard > run.
- States:
  - RUN: no stall. issue_o = id_valid_i.
  - STALL (hazard): pc_hold_o=1, if_id_hold_o=1, ld_bubble_o=1, issue_o=0.
  - HOLD (ex_busy_i): pc_hold_o=1, if_id_hold_o=1, ld_hold_o=1, issue_o=0.
  - FLUSH: if_id_flush_o=1, ld_flush_o=1, issue_o=0.
- State is re-evaluated every cycle from the inputs. STALL and HOLD exit the cycle their cause deasserts.
- Jump timing:
  - In the cycle ex_jump_i=1 (any state): pc_load_o=1, pc_load_addr_o=ex_jump_addr_i, both flush outputs=1, issue_o=0. This is combinational, same cycle.
  - The counter loads FLUSH_CYCLES-1. Flush outputs stay high while the counter is nonzero; it decrements each cycle. pc_load_o is a one-cycle pulse.
  - A new ex_jump_i during FLUSH reloads the counter and pulses pc_load_o again.
  - ex_busy_i together with ex_jump_i: the jump wins.
- Scoreboard set: sb[id_rd_addr_i] is set when issue_o & id_rd_wr_i & id_long_i & rd!=0. The ld slot records {valid, rd} of that instruction.
- Scoreboard clear: wb_valid_i clears sb[wb_rd_addr_i]. If the same index is set and cleared in one cycle, set wins.
- Flush undo: when ld_flush_o is asserted and the ld slot is valid, that slot's bit is cleared and the slot is invalidated.
- The ld slot advances (invalidates) on any cycle with ld_hold_o=0 and issue_o=0.
- wb to x0 and hazard checks on x0 are ignored; sb[0] is always 0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding: RUN=2'd0, STALL=2'd1, HOLD=2'd2, FLUSH=2'd3
  - NOP_INST=32'h00000013
  - NREG and register-index width
- One sub-module, pipe_scoreboard, owns:
  - the set/clear/undo of sb
  - the ld slot
  - the hazard lookup (combinational read, registered state)

Test Plan:
- Reset: hold rst=0 for 3 cycles while ex_jump_i=1 -> all outputs 0, sb_o=0, state_o=0. Release -> state_o=0 and issue_o follows id_valid_i.
- Load-use: issue lw x5 (id_long_i=1), next cycle add x6,x5,x1 -> sb_o[5]=1, STALL (ld_bubble_o=1) until wb_valid_i with rd=5. issue_o=1 exactly one cycle after wb.
- Jump: ex_jump_i=1, addr=32'h0000_0080, FLUSH_CYCLES=2 -> pc_load_o pulse 1 cycle with 0x80. Flush outputs high 2 cycles. The ld slot's pending bit (lw x7 in ld) is cleared, so sb_o[7] goes 0.
- Busy vs hazard: ex_busy_i=1 for 4 cycles while a hazard is present -> state HOLD (ld_hold_o=1, ld_bubble_o=0) for 4 cycles, then STALL until wb.
- Same-cycle set/clear: wb x9 while issuing a new lw x9 -> sb_o[9] stays 1. x0 writes: lw x0 -> sb_o[0] stays 0, no stall on a dependent instruction.
- Back-to-back jumps: second ex_jump_i during FLUSH -> second pc_load_o pulse with the new address, counter restarted, 2 further flush cycles.
